// File: rtl/acc_stream_gather.sv
// Gathers a 64-bit word stream into NUM_WORDS-word frames using two ping-pong banks.
// The filling bank is never the presented bank, so a frame can close and another can release in the same cycle.
module acc_stream_gather #(
    parameter int NUM_WORDS = 64,
    parameter int DATA_W    = 64,
    localparam int CNT_W    = $clog2(NUM_WORDS + 1),
    localparam int IDX_W    = $clog2(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [NUM_WORDS*DATA_W-1:0] frame_data,
    output logic [CNT_W-1:0]            frame_count,
    output logic                        frame_short
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    bank_state_e       bank_state_r [2];
    logic [CNT_W-1:0]  bank_count_r [2];
    logic              bank_short_r [2];
    logic [DATA_W-1:0] mem_r        [2][NUM_WORDS];
    logic              wr_sel_r;
    logic              rd_sel_r;
    logic [IDX_W-1:0]  wr_cnt_r;

    logic              accept_s;
    logic              last_slot_s;
    logic              close_s;
    logic              release_s;

    // Handshake decode; clear masks any accept or release in its cycle
    always_comb begin
        in_ready    = clear | (bank_state_r[wr_sel_r] != BANK_FULL);
        frame_valid = (bank_state_r[rd_sel_r] == BANK_FULL);
        accept_s    = in_valid & in_ready & ~clear;
        last_slot_s = (wr_cnt_r == IDX_W'(NUM_WORDS - 1));
        close_s     = accept_s & (last_slot_s | in_last);
        release_s   = frame_valid & frame_ready & ~clear;
    end

    // Bank state, pointers and per-bank frame metadata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_r[b] <= BANK_EMPTY;
                bank_count_r[b] <= '0;
                bank_short_r[b] <= 1'b0;
            end
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            wr_cnt_r <= '0;
        end else if (clear) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_r[b] <= BANK_EMPTY;
                bank_count_r[b] <= '0;
                bank_short_r[b] <= 1'b0;
            end
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            wr_cnt_r <= '0;
        end else begin
            if (close_s) begin
                bank_state_r[wr_sel_r] <= BANK_FULL;
                bank_count_r[wr_sel_r] <= CNT_W'(wr_cnt_r) + CNT_W'(1);
                bank_short_r[wr_sel_r] <= in_last & ~last_slot_s;
                wr_sel_r               <= ~wr_sel_r;
                wr_cnt_r               <= '0;
            end else if (accept_s) begin
                bank_state_r[wr_sel_r] <= BANK_FILLING;
                wr_cnt_r               <= wr_cnt_r + IDX_W'(1);
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
            // Release targets the presented bank, which is never the one being written
            if (release_s) begin
                bank_state_r[rd_sel_r] <= BANK_EMPTY;
                rd_sel_r               <= ~rd_sel_r;
            end else begin
                rd_sel_r <= rd_sel_r;
            end
        end
    end

    // Word storage; contents are don't-care after reset because the output is masked
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_sel_r][wr_cnt_r] <= in_data;
        end
    end

    // Present the held frame, zeroing words beyond its count and everything when idle
    always_comb begin
        frame_data  = '0;
        frame_count = '0;
        frame_short = 1'b0;
        if (frame_valid) begin
            frame_count = bank_count_r[rd_sel_r];
            frame_short = bank_short_r[rd_sel_r];
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (CNT_W'(i) < bank_count_r[rd_sel_r]) begin
                    frame_data[i*DATA_W +: DATA_W] = mem_r[rd_sel_r][IDX_W'(i)];
                end else begin
                    frame_data[i*DATA_W +: DATA_W] = '0;
                end
            end
        end else begin
            frame_data  = '0;
            frame_count = '0;
            frame_short = 1'b0;
        end
    end

endmodule
